ram_ctrl_param: RTL
===================

Name: ram_ctrl_param

Overview:
- Parametrised successor to the team's single-port 32x9 RAM.
- Adds:
  - configurable width and depth;
  - a write-collision read mode;
  - a registered read path with a valid strobe;
  - an automatic zero-fill sequencer after reset and on request, with a ready flag.
- Sits between the datapath/controller and local storage, used as register file or scratch memory.

Parameters:
- DATA_W, 9, data word width in bits.
- ADDR_W, 5, address width.
- DEPTH, 32, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W.
- WRITE_MODE, 0, read behaviour on a write cycle: 0 = NO_CHANGE, 1 = WRITE_FIRST.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- res  input  1  synchronous active-low reset; 0 at a clk edge resets the block.
- en  input  1  access request, sampled only while ready=1.
- wr  input  1  1 = write, 0 = read; qualified by en.
- addr  input  ADDR_W  word address.
- din  input  DATA_W  write data.
- clr  input  1  soft zero-fill request, sampled only while ready=1.
- dout  output  DATA_W  registered read data.
- rvalid  output  1  one-cycle strobe marking a new dout value.
- ready  output  1  1 when accesses are accepted.
- oob  output  1  one-cycle strobe for an accepted access with addr >= DEPTH.
- par_err  output  1  parity error strobe; tied 0 when the optional feature is absent.

Behaviour:
- Reset (res=0 at clk edge):
  - state=CLEAR, clear pointer=0;
  - dout=0, rvalid=0, ready=0, oob=0, par_err=0.
  - Memory contents are not reset directly; the CLEAR state zeroes them.
  - Reset asserted mid-CLEAR restarts the clear at pointer 0.
  - Reset mid-IDLE aborts any pending read: rvalid=0 next cycle.
- FSM states: CLEAR, IDLE.
- CLEAR:
  - Each cycle writes 0 to mem[ptr], then ptr++.
  - When ptr==DEPTH-1 has been written, the next state is IDLE.
  - CLEAR lasts exactly DEPTH cycles; ready rises on the first IDLE cycle.
  - en and clr are ignored during CLEAR; rvalid, oob and par_err stay 0.
- IDLE, ready=1:
  - en=1, wr=1, addr<DEPTH: mem[addr]<=din at this edge.
  - en=1, wr=0, addr<DEPTH: dout<=mem[addr] and rvalid=1 one cycle after the request edge (1-cycle latency).
  - Back-to-back reads are allowed every cycle.
  - en=1, wr=1 with WRITE_MODE=0: dout holds its value, rvalid=0.
  - en=1, wr=1 with WRITE_MODE=1: dout<=din and rvalid=1 next cycle.
  - addr>=DEPTH with en=1:
    - a write is dropped;
    - a read returns dout=0 with rvalid=1;
    - oob=1 for one cycle aligned with the rvalid slot (writes included).
  - A read from an address immediately after a write to it returns the new data.
  - en=0: no memory access; rvalid=0; dout holds.
- clr=1 in IDLE:
  - Enters CLEAR next cycle; ready=0 from that cycle.
  - If en=1 in the same cycle, clr wins and the access is discarded.
  - dout holds its last value through CLEAR.
- Widths: ptr is ADDR_W bits. There is no wrap-around past DEPTH-1; the pointer stops and the FSM leaves CLEAR.

Optional Feature:
- Macro: RAM_PARITY_EN.
- Defined:
  - Each word stores DATA_W+1 bits: data plus the even parity of data.
  - Writes and the CLEAR zero-fill store correct parity.
  - An in-range read recomputes parity. A mismatch gives par_err=1 for one cycle, aligned with rvalid; dout still shows the stored data.
  - The extra input port err_inj (1 bit) inverts the stored parity bit on a write, for test.
- Undefined:
  - Storage is DATA_W bits.
  - par_err is constant 0.
  - The err_inj port is absent.

Decomposition:
- Package ram_pkg:
  - state encoding (CLEAR=1'b0, IDLE=1'b1);
  - WRITE_MODE constants NO_CHANGE=0, WRITE_FIRST=1;
  - a parity function.
- One sub-module, ram_clear_seq: the pointer counter plus done flag, with inputs start, res, clk and outputs ptr, busy, done.
- The array, the access mux and the FSM live in ram_ctrl_param.

Test Plan:
- Reset, then release res=1 at t0 (defaults):
  - ready=0 for exactly 32 cycles, then 1;
  - a read of addr 5'h04 gives dout=9'h000, rvalid=1 one cycle later.
- Write addr 5'h04 = 9'h199, write addr 5'h05 = 9'h1FF, then read 5'h04, 5'h05 back-to-back:
  - dout=9'h199 then 9'h1FF on consecutive cycles, with rvalid high for 2 cycles.
- WRITE_MODE=1, write addr 5'h02 = 9'h0AA:
  - next cycle dout=9'h0AA, rvalid=1.
  - With WRITE_MODE=0, the same stimulus leaves dout unchanged and rvalid=0.
- DEPTH=20, ADDR_W=5:
  - write addr 5'd25 = 9'h155, then read 5'd25: dout=0, rvalid=1, oob pulses on both accesses;
  - read of 5'd19 is unaffected.
- Assert clr with en=1, wr=1, addr 5'h04, din=9'h123 in the same cycle:
  - write discarded, ready low for DEPTH cycles;
  - then a read of 5'h04 returns 9'h000.
  - Pull res=0 at clear cycle 10: clear restarts, ready rises DEPTH cycles after res=1.
- With RAM_PARITY_EN:
  - write 5'h07 = 9'h101 with err_inj=1, then read 5'h07: dout=9'h101, par_err=1 with rvalid;
  - a read after an err_inj=0 write gives par_err=0.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and helpers for the parametrised RAM controller.
// State encoding, write-mode selectors and the parity helper.
package ram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_t;

   localparam int NO_CHANGE   = 0;
   localparam int WRITE_FIRST = 1;

   // Even parity bit: XOR of all data bits, so data plus this bit has even weight.
   function automatic logic even_par(input logic [63:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Zero-fill address sequencer: walks ptr from 0 up to DEPTH-1, once per cycle.
// Restarts on reset or start; done marks the cycle that writes the last word.
module ram_clear_seq #(
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 32
) (
   input  logic              clk,
   input  logic              res,
   input  logic              start,
   output logic [ADDR_W-1:0] ptr,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   always_ff @(posedge clk) begin
      if (!res || start) begin
         ptr  <= '0;
         busy <= 1'b1;
      end else if (busy) begin
         if (ptr == LAST) begin
            busy <= 1'b0;
         end else begin
            ptr <= ptr + 1'b1;
         end
      end
   end

   assign done = busy && (ptr == LAST);

endmodule

// File: rtl/ram_ctrl_param.sv
// Parametrised single-port RAM with registered read, zero-fill sequencer and ready flag.
// Optional per-word parity with error injection when RAM_PARITY_EN is defined.
//
// state | meaning
// CLEAR | zero-filling memory via ram_clear_seq; accesses ignored, ready=0
// IDLE  | accepting reads/writes; ready=1
module ram_ctrl_param
   import ram_pkg::*;
#(
   parameter int DATA_W     = 9,
   parameter int ADDR_W     = 5,
   parameter int DEPTH      = 32,
   parameter int WRITE_MODE = NO_CHANGE
) (
   input  logic              clk,
   input  logic              res,
   input  logic              en,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   input  logic              clr,
`ifdef RAM_PARITY_EN
   input  logic              err_inj,
`endif
   output logic [DATA_W-1:0] dout,
   output logic              rvalid,
   output logic              ready,
   output logic              oob,
   output logic              par_err
);

`ifdef RAM_PARITY_EN
   localparam int MEM_W = DATA_W + 1;
`else
   localparam int MEM_W = DATA_W;
`endif
   localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W + 1)'(DEPTH);

   state_t              state;
   logic [ADDR_W-1:0]   ptr;
   logic                busy;
   logic                done;
   logic                start;

   logic [MEM_W-1:0]    mem [DEPTH];
   logic [MEM_W-1:0]    rd_word;
   logic [MEM_W-1:0]    acc_wdata;
   logic [MEM_W-1:0]    mem_wdata;
   logic [IDX_W-1:0]    mem_idx;
   logic                mem_we;
   logic                in_range;
   logic                rd_par_err;

   ram_clear_seq #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_clear_seq (
      .clk   (clk),
      .res   (res),
      .start (start),
      .ptr   (ptr),
      .busy  (busy),
      .done  (done)
   );

   always_comb begin
      in_range = ({1'b0, addr} < DEPTH_V);
      start    = res && (state == IDLE) && clr;
      rd_word  = mem[addr[IDX_W-1:0]];
`ifdef RAM_PARITY_EN
      acc_wdata  = {even_par(64'(din)) ^ err_inj, din};
      rd_par_err = even_par(64'(rd_word[DATA_W-1:0])) != rd_word[DATA_W];
`else
      acc_wdata  = din;
      rd_par_err = 1'b0;
`endif
      mem_we    = 1'b0;
      mem_idx   = addr[IDX_W-1:0];
      mem_wdata = acc_wdata;
      // All-zero words carry correct even parity, so the fill needs no parity logic.
      if (res && busy) begin
         mem_we    = 1'b1;
         mem_idx   = ptr[IDX_W-1:0];
         mem_wdata = '0;
      end else if (res && (state == IDLE) && !clr && en && wr && in_range) begin
         mem_we = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_idx] <= mem_wdata;
      end
   end

   always_ff @(posedge clk) begin
      rvalid  <= 1'b0;
      oob     <= 1'b0;
      par_err <= 1'b0;
      if (!res) begin
         state <= CLEAR;
         ready <= 1'b0;
         dout  <= '0;
      end else begin
         case (state)
            CLEAR: begin
               if (done) begin
                  state <= IDLE;
                  ready <= 1'b1;
               end
            end
            IDLE: begin
               if (clr) begin
                  state <= CLEAR;
                  ready <= 1'b0;
               end else if (en) begin
                  if (!in_range) begin
                     oob <= 1'b1;
                     if (!wr) begin
                        dout   <= '0;
                        rvalid <= 1'b1;
                     end
                  end else if (wr) begin
                     if (WRITE_MODE == WRITE_FIRST) begin
                        dout   <= din;
                        rvalid <= 1'b1;
                     end
                  end else begin
                     dout    <= rd_word[DATA_W-1:0];
                     rvalid  <= 1'b1;
                     par_err <= rd_par_err;
                  end
               end
            end
            default: begin
               state <= CLEAR;
               ready <= 1'b0;
            end
         endcase
      end
   end

endmodule
